// File: rtl/health_pkg.sv
// Shared types and constants for the player health controller.
package health_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ALIVE  = 2'd1,
    INVULN = 2'd2,
    DEAD   = 2'd3
  } state_e;

  localparam int FCNT_W         = 8;
  localparam int DEF_MAX_HEARTS = 3;

endpackage

// File: rtl/frame_downcounter.sv
// Loadable frame-tick down-counter; done flags a count of one.
// Priority: clr over load over tick; it parks at zero.
module frame_downcounter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         tick,
  output logic         done
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (tick && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign done = (cnt_q == W'(1));

endmodule

// File: rtl/health_ctrl.sv
// Player heart count, post-hit invulnerability with sprite blink, game over.
// Optional frame-based heart regeneration under HEALTH_REGEN_EN.
module health_ctrl
  import health_pkg::*;
#(
  parameter int MAX_HEARTS    = DEF_MAX_HEARTS,
  parameter int INVULN_FRAMES = 60,
  parameter int BLINK_FRAMES  = 4
`ifdef HEALTH_REGEN_EN
  ,
  parameter int REGEN_FRAMES  = 600
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       game_start,
  input  logic       hit,
  input  logic       heal,
  output logic [1:0] num_hearts,
  output logic       invuln,
  output logic       sprite_visible,
  output logic       dead,
  output logic       life_lost
);

  localparam logic [1:0] MAX_H = 2'(MAX_HEARTS);

  state_e     state_q, state_d;
  logic [1:0] hearts_q, hearts_d;
  logic       invuln_q, invuln_d;
  logic       vis_q, vis_d;
  logic       dead_q, dead_d;
  logic       lost_q, lost_d;

  logic inv_tick, inv_done, blk_done;
  logic inv_load, inv_clr, blk_load, blk_clr;
  logic hit_acc, can_heal, regen_inc, gain;

  assign inv_tick = frame_tick && (state_q == INVULN);
  assign can_heal = (hearts_q < MAX_H);
  assign gain     = (heal || regen_inc) && can_heal;

  frame_downcounter #(.W(FCNT_W)) u_inv (
    .clk      (clk),
    .rst      (rst),
    .clr      (inv_clr),
    .load     (inv_load),
    .load_val (FCNT_W'(INVULN_FRAMES)),
    .tick     (inv_tick),
    .done     (inv_done)
  );

  frame_downcounter #(.W(FCNT_W)) u_blink (
    .clk      (clk),
    .rst      (rst),
    .clr      (blk_clr),
    .load     (blk_load),
    .load_val (FCNT_W'(BLINK_FRAMES)),
    .tick     (inv_tick),
    .done     (blk_done)
  );

`ifdef HEALTH_REGEN_EN
  localparam int RW = $clog2(REGEN_FRAMES + 1);

  logic rg_elig, rg_done, rg_load;

  assign rg_elig   = ((state_q == ALIVE) || (state_q == INVULN))
                     && can_heal;
  assign regen_inc = frame_tick && rg_elig && rg_done && !game_start;
  // Holding the reload while ineligible restarts the count cleanly.
  assign rg_load   = !rg_elig || hit_acc || game_start || regen_inc;

  frame_downcounter #(.W(RW)) u_regen (
    .clk      (clk),
    .rst      (rst),
    .clr      (1'b0),
    .load     (rg_load),
    .load_val (RW'(REGEN_FRAMES)),
    .tick     (frame_tick && rg_elig),
    .done     (rg_done)
  );
`else
  assign regen_inc = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    hearts_d = hearts_q;
    vis_d    = vis_q;
    lost_d   = 1'b0;
    hit_acc  = 1'b0;
    inv_load = 1'b0;
    inv_clr  = 1'b0;
    blk_load = 1'b0;
    blk_clr  = 1'b0;
    if (game_start) begin
      state_d  = ALIVE;
      hearts_d = MAX_H;
      vis_d    = 1'b1;
      inv_clr  = 1'b1;
      blk_clr  = 1'b1;
    end else begin
      unique case (state_q)
        ALIVE: begin
          if (hit) begin
            hit_acc = 1'b1;
            lost_d  = 1'b1;
            if (hearts_q > 2'd1) begin
              hearts_d = hearts_q - 2'd1;
              state_d  = INVULN;
              vis_d    = 1'b0;
              inv_load = 1'b1;
              blk_load = 1'b1;
            end else begin
              hearts_d = 2'd0;
              state_d  = DEAD;
            end
          end else if (gain) begin
            hearts_d = hearts_q + 2'd1;
          end
        end
        INVULN: begin
          if (gain) hearts_d = hearts_q + 2'd1;
          if (inv_tick && inv_done) begin
            state_d = ALIVE;
            vis_d   = 1'b1;
            blk_clr = 1'b1;
          end else if (inv_tick && blk_done) begin
            vis_d    = !vis_q;
            blk_load = 1'b1;
          end
        end
        default: ;
      endcase
    end
    invuln_d = (state_d == INVULN);
    dead_d   = (state_d == DEAD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      hearts_q <= MAX_H;
      invuln_q <= 1'b0;
      vis_q    <= 1'b1;
      dead_q   <= 1'b0;
      lost_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      hearts_q <= hearts_d;
      invuln_q <= invuln_d;
      vis_q    <= vis_d;
      dead_q   <= dead_d;
      lost_q   <= lost_d;
    end
  end

  assign num_hearts     = hearts_q;
  assign invuln         = invuln_q;
  assign sprite_visible = vis_q;
  assign dead           = dead_q;
  assign life_lost      = lost_q;

endmodule

// File: tb/tb_health_ctrl.sv
// Directed self-checking bench for health_ctrl.
// With HEALTH_REGEN_EN it runs the regeneration sequence instead.
module tb_health_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic       game_start = 1'b0;
  logic       hit = 1'b0;
  logic       heal = 1'b0;
  logic [1:0] num_hearts;
  logic       invuln;
  logic       sprite_visible;
  logic       dead;
  logic       life_lost;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

`ifdef HEALTH_REGEN_EN
  health_ctrl #(
    .MAX_HEARTS    (3),
    .INVULN_FRAMES (2),
    .BLINK_FRAMES  (4),
    .REGEN_FRAMES  (5)
  ) dut (
`else
  health_ctrl #(
    .MAX_HEARTS    (3),
    .INVULN_FRAMES (60),
    .BLINK_FRAMES  (4)
  ) dut (
`endif
    .clk            (clk),
    .rst            (rst),
    .frame_tick     (frame_tick),
    .game_start     (game_start),
    .hit            (hit),
    .heal           (heal),
    .num_hearts     (num_hearts),
    .invuln         (invuln),
    .sprite_visible (sprite_visible),
    .dead           (dead),
    .life_lost      (life_lost)
  );

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // One clock with the given pulses; outputs are sampled 1ns after the edge.
  task automatic cyc(input logic gs, input logic h,
                     input logic hl, input logic ft);
    game_start = gs;
    hit        = h;
    heal       = hl;
    frame_tick = ft;
    @(posedge clk);
    #1;
    game_start = 1'b0;
    hit        = 1'b0;
    heal       = 1'b0;
    frame_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_hearts", num_hearts, 3);
    chk("rst_invuln", invuln, 0);
    chk("rst_vis", sprite_visible, 1);
    chk("rst_dead", dead, 0);
    chk("rst_lost", life_lost, 0);

`ifdef HEALTH_REGEN_EN
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0);
    chk("rg_hit", num_hearts, 2);
    ticks(4);
    chk("rg_4", num_hearts, 2);
    ticks(1);
    chk("rg_5", num_hearts, 3);
    cyc(0, 1, 0, 0);
    ticks(2);
    chk("rg_alive", invuln, 0);
    cyc(0, 1, 0, 1);
    chk("rg_hit3", num_hearts, 1);
    ticks(4);
    chk("rg_restart4", num_hearts, 1);
    ticks(1);
    chk("rg_restart5", num_hearts, 2);
`else
    cyc(0, 1, 0, 0);
    cyc(0, 0, 1, 0);
    chk("idle_hearts", num_hearts, 3);
    chk("idle_lost", life_lost, 0);
    chk("idle_invuln", invuln, 0);

    cyc(1, 0, 0, 0);
    chk("start_hearts", num_hearts, 3);
    chk("start_vis", sprite_visible, 1);
    chk("start_dead", dead, 0);

    cyc(0, 1, 0, 0);
    chk("hit_hearts", num_hearts, 2);
    chk("hit_lost", life_lost, 1);
    chk("hit_invuln", invuln, 1);
    chk("hit_vis", sprite_visible, 0);
    cyc(0, 0, 0, 0);
    chk("lost_pulse", life_lost, 0);

    ticks(3);
    chk("blink_t3", sprite_visible, 0);
    ticks(1);
    chk("blink_t4", sprite_visible, 1);
    ticks(3);
    chk("blink_t7", sprite_visible, 1);
    ticks(1);
    chk("blink_t8", sprite_visible, 0);
    ticks(2);

    cyc(0, 1, 0, 0);
    chk("inv_hit_hearts", num_hearts, 2);
    chk("inv_hit_lost", life_lost, 0);
    ticks(49);
    chk("inv_t59", invuln, 1);
    chk("vis_t59", sprite_visible, 0);
    ticks(1);
    chk("inv_t60", invuln, 0);
    chk("vis_t60", sprite_visible, 1);

    cyc(0, 0, 1, 0);
    chk("heal_2to3", num_hearts, 3);
    cyc(0, 0, 1, 0);
    chk("heal_sat", num_hearts, 3);

    cyc(0, 1, 0, 0);
    cyc(0, 1, 1, 0);
    chk("inv_heal_hit", num_hearts, 3);
    chk("inv_heal_lost", life_lost, 0);
    ticks(5);
    cyc(1, 0, 0, 0);
    chk("gs_mid_hearts", num_hearts, 3);
    chk("gs_mid_invuln", invuln, 0);
    chk("gs_mid_vis", sprite_visible, 1);

    cyc(0, 1, 0, 0);
    ticks(60);
    chk("alive2_invuln", invuln, 0);
    cyc(0, 1, 1, 1);
    chk("hitheal_hearts", num_hearts, 1);
    chk("hitheal_invuln", invuln, 1);
    chk("hitheal_lost", life_lost, 1);
    ticks(59);
    chk("tickhit_t59", invuln, 1);
    ticks(1);
    chk("tickhit_t60", invuln, 0);

    cyc(0, 1, 0, 0);
    chk("fatal_hearts", num_hearts, 0);
    chk("fatal_dead", dead, 1);
    chk("fatal_lost", life_lost, 1);
    chk("fatal_invuln", invuln, 0);
    cyc(0, 0, 1, 0);
    chk("dead_heal", num_hearts, 0);
    cyc(1, 0, 0, 0);
    chk("restart_hearts", num_hearts, 3);
    chk("restart_dead", dead, 0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/health_ctrl.md
Name: health_ctrl

Overview:
- Owns the player's heart count and feeds `num_hearts` to the heart-bar renderer.
- Accepts single-cycle hit/heal events from game logic and applies a frame-counted invulnerability window after each hit.
- Generates the sprite blink enable used during that window, and flags game over.
- Sits between collision/pickup logic and the display pipeline; one instance per player.

Parameters:
- MAX_HEARTS, 3, heart count at start and saturation ceiling (1..3, fits 2 bits).
- INVULN_FRAMES, 60, frames of invulnerability after a non-fatal hit (1..255).
- BLINK_FRAMES, 4, frames per sprite on/off phase during invulnerability (1..255).
- REGEN_FRAMES, 600, frames between automatic heals (used only with the optional feature).

Ports:
- clk  in  1  system/pixel clock.
- rst  in  1  synchronous active-high reset.
- frame_tick  in  1  one-cycle pulse per video frame (end of active area).
- game_start  in  1  one-cycle pulse; (re)starts a game.
- hit  in  1  one-cycle damage event.
- heal  in  1  one-cycle heart-pickup event.
- num_hearts  out  2  current hearts (0..MAX_HEARTS).
- invuln  out  1  high while in the invulnerability window.
- sprite_visible  out  1  player sprite enable (blinks during invulnerability).
- dead  out  1  high in DEAD state.
- life_lost  out  1  one-cycle pulse on every accepted hit.

Behaviour:
- All outputs are registered.
- Reset: state IDLE, num_hearts=MAX_HEARTS, invuln=0, sprite_visible=1, dead=0, life_lost=0, counters=0.
- States and transitions:
  - IDLE: hit and heal ignored. game_start -> ALIVE.
  - ALIVE:
    - hit with num_hearts>1 -> num_hearts-1, life_lost=1 next cycle, inv_cnt=INVULN_FRAMES, blink_cnt=BLINK_FRAMES, sprite_visible=0 -> INVULN.
    - hit with num_hearts==1 -> num_hearts=0, life_lost=1 -> DEAD.
    - heal with num_hearts<MAX_HEARTS -> +1; saturates at MAX_HEARTS, never wraps.
  - INVULN:
    - hit ignored; no life_lost.
    - heal accepted as in ALIVE.
    - On each frame_tick, inv_cnt decrements.
    - Leaves to ALIVE on the frame_tick where inv_cnt==1; inv_cnt is 0 afterwards, sprite_visible forced to 1 in that same cycle.
    - blink_cnt decrements on frame_tick; at 1 it reloads BLINK_FRAMES and sprite_visible toggles.
  - DEAD: dead=1, num_hearts=0; hit and heal ignored. game_start -> ALIVE.
- Outputs per state:
  - invuln is 1 exactly while in INVULN.
  - sprite_visible is 1 in every state except during INVULN off-phases.
- game_start in any state (including mid-INVULN) has the highest priority after rst:
  - num_hearts=MAX_HEARTS, counters cleared, sprite_visible=1 -> ALIVE.
  - Any simultaneous hit or heal is dropped.
- Same-cycle hit and heal in ALIVE: hit wins, heal dropped.
- Same-cycle hit and heal in INVULN: heal applied.
- Latency: events take effect on the cycle after they are sampled. hit/heal are not queued; pulses in ignored states are lost.
- frame_tick coincident with a hit in ALIVE: the counters load, and that tick is not counted.

Optional Feature:
- Macro HEALTH_REGEN_EN.
- Defined:
  - regen_cnt counts frame_tick while in ALIVE or INVULN with num_hearts<MAX_HEARTS.
  - On reaching REGEN_FRAMES, regen_cnt clears and num_hearts increments (saturating).
  - regen_cnt clears on any accepted hit, on game_start and on reaching MAX_HEARTS.
  - An explicit heal in the same cycle as the regen increment adds only one heart total.
- Undefined: no regen logic and no REGEN_FRAMES use; behaviour identical to the above otherwise.

Decomposition:
- health_pkg (include/package) holds:
  - state encodings: IDLE=2'd0, ALIVE=2'd1, INVULN=2'd2, DEAD=2'd3;
  - counter width constant FCNT_W=8;
  - default MAX_HEARTS.
- One natural sub-module: frame_downcounter, a loadable frame-tick down-counter with `done` at 1. Instantiate it for inv_cnt and blink_cnt, plus regen when HEALTH_REGEN_EN is defined.

Test Plan:
- rst, then game_start -> state ALIVE, num_hearts=3, sprite_visible=1, dead=0; hit/heal before game_start leave num_hearts=3.
- In ALIVE with 3 hearts, pulse hit -> num_hearts=2, one-cycle life_lost, invuln=1; second hit 10 frames later ignored; invuln falls on the 60th frame_tick.
- During INVULN with BLINK_FRAMES=4 -> sprite_visible reads 0 for frames 1-4 and 1 for frames 5-8, alternating; it is 1 when invuln drops.
- From 1 heart, hit -> num_hearts=0, dead=1; heal ignored; game_start -> num_hearts=3, dead=0.
- At 3 hearts, heal -> stays 3. At 2 hearts in ALIVE, hit+heal same cycle -> 1 heart, INVULN. game_start mid-INVULN -> ALIVE, 3 hearts, invuln=0.
- HEALTH_REGEN_EN with REGEN_FRAMES=5 at 2 hearts -> 3 hearts after 5 frame_ticks. A hit at frame 3 restarts the count.
